// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Imported by mem_arbiter and arb_timeout_ctr.
package mem_arb_pkg;

   localparam int unsigned TimeoutW = 16;

   typedef enum logic [1:0] {
      StIdle,
      StGrantI,
      StGrantD
   } arb_state_t;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Wait-cycle counter for an outstanding memory command.
// Flags expiry on the Timeout-th wait cycle without an ack.
module arb_timeout_ctr
   import mem_arb_pkg::*;
#(
   parameter int unsigned Timeout = 255
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic load_i,
   input  logic enable_i,
   output logic expire_o
);

   logic [TimeoutW-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= '0;
      end else if (enable_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // cnt_q holds the number of wait cycles already spent, so this is the last allowed one
   assign expire_o = enable_i && (cnt_q == TimeoutW'(Timeout - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between a fetch and a data requester.
// Define ARB_RR_EN for round-robin tie-breaking; default is fixed data priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_adr,
   output logic          i_done,
   output logic [DW-1:0] i_rdata,
   output logic          i_err,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_adr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_done,
   output logic [DW-1:0] d_rdata,
   output logic          d_err,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack
);

   arb_state_t state_q;
   logic       grant_d;
   logic       tmo_load;
   logic       tmo_en;
   logic       tmo_expire;

`ifdef ARB_RR_EN
   logic last_d_q;
   // On a tie, whoever was not served last wins
   assign grant_d = d_req && (!i_req || !last_d_q);
`else
   assign grant_d = d_req;
`endif

   assign tmo_load = (state_q == StIdle);
   assign tmo_en   = (state_q != StIdle) && !mem_ack;

   arb_timeout_ctr #(
      .Timeout(TIMEOUT)
   ) u_timeout (
      .clk_i   (clk),
      .reset_i (reset),
      .load_i  (tmo_load),
      .enable_i(tmo_en),
      .expire_o(tmo_expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_adr   <= '0;
         mem_wdata <= '0;
         i_done    <= 1'b0;
         i_err     <= 1'b0;
         i_rdata   <= '0;
         d_done    <= 1'b0;
         d_err     <= 1'b0;
         d_rdata   <= '0;
`ifdef ARB_RR_EN
         last_d_q  <= 1'b0;
`endif
      end else begin
         i_done <= 1'b0;
         i_err  <= 1'b0;
         d_done <= 1'b0;
         d_err  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // Requesters still hold req during their done cycle, so never grant then
               if (!i_done && !d_done) begin
                  if (grant_d) begin
                     state_q   <= StGrantD;
                     mem_req   <= 1'b1;
                     mem_we    <= d_we;
                     mem_adr   <= d_adr;
                     mem_wdata <= d_wdata;
`ifdef ARB_RR_EN
                     last_d_q  <= 1'b1;
`endif
                  end else if (i_req) begin
                     state_q   <= StGrantI;
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b0;
                     mem_adr   <= i_adr;
                     mem_wdata <= '0;
`ifdef ARB_RR_EN
                     last_d_q  <= 1'b0;
`endif
                  end
               end
            end
            StGrantI, StGrantD: begin
               if (mem_ack || tmo_expire) begin
                  state_q <= StIdle;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (state_q == StGrantD) begin
                     d_done <= 1'b1;
                     d_err  <= !mem_ack;
                     if (mem_ack) d_rdata <= mem_rdata;
                  end else begin
                     i_done <= 1'b1;
                     i_err  <= !mem_ack;
                     if (mem_ack) i_rdata <= mem_rdata;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32: address width.
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum memory wait cycles before abort (1..65535).
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports i_req (input, 1) and i_adr (input, AW): instruction-fetch read request and address.
REQ-007 SHALL have ports i_done (output, 1), i_rdata (output, DW) and i_err (output, 1): fetch completion pulse, read data and error flag.
REQ-008 SHALL have ports d_req (input, 1), d_we (input, 1), d_adr (input, AW) and d_wdata (input, DW): data-access request.
REQ-009 SHALL have ports d_done (output, 1), d_rdata (output, DW) and d_err (output, 1): data-access completion pulse, read data and error flag.
REQ-010 SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_adr (output, AW) and mem_wdata (output, DW): shared single-port memory command.
REQ-011 SHALL have ports mem_rdata (input, DW) and mem_ack (input, 1): memory read data and completion, ack valid for one cycle.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT_I, GRANT_D.
REQ-013 SHALL, in IDLE, sample requests; next state GRANT_D if d_req, else GRANT_I if i_req, else IDLE (fixed data priority).
REQ-014 SHALL register the winner's adr, we and wdata at grant; i_we is implicitly 0.
REQ-015 SHALL assert mem_req with the registered command during every GRANT_I/GRANT_D cycle, and deassert it in IDLE.
REQ-016 SHALL, on mem_ack in GRANT_x, pulse x_done for exactly one cycle (the cycle after ack), drive x_rdata from the captured mem_rdata, and return to IDLE.
REQ-017 SHALL hold x_rdata stable until the next x_done; d_rdata is don't-care after a write.
REQ-018 SHALL take minimum latency from request to done of 3 cycles: grant, ack in first mem_req cycle, done.
REQ-019 SHALL require requesters to hold req and command stable until done; a req dropped mid-transaction SHALL NOT abort it, and done SHALL still pulse.
REQ-020 SHALL count wait cycles in GRANT_x with a 16-bit counter cleared at grant; on reaching TIMEOUT without ack, SHALL pulse x_done together with x_err, drop mem_req, and return to IDLE.
REQ-021 SHALL ignore mem_ack in IDLE.
REQ-022 SHALL not re-grant during the done cycle: IDLE is always at least one cycle, so back-to-back transactions are spaced by one idle cycle.
REQ-023 SHALL evaluate i_req and d_req asserted in the same IDLE cycle per REQ-013, or per REQ-028 when ARB_RR_EN is defined.

Reset
REQ-024 SHALL, on reset, force state IDLE, mem_req=0, mem_we=0, i_done=d_done=0, i_err=d_err=0, counters=0, and rdata registers=0.
REQ-025 SHALL abandon any in-flight transaction on reset mid-operation with no done pulse; a late mem_ack SHALL be ignored.
REQ-026 SHALL clear the round-robin pointer (when present) on reset, giving data priority first.

Configuration
REQ-027 SHALL use macro ARB_RR_EN.
REQ-028 SHALL, when ARB_RR_EN is defined, resolve simultaneous requests round-robin via a 1-bit last-grant register: the requester not served last wins.
REQ-029 SHALL, when ARB_RR_EN is undefined, use fixed data priority, and the pointer SHALL not exist.

Structure
REQ-030 SHALL take the state enum arb_state_t and the TIMEOUT counter width constant from package mem_arb_pkg.
REQ-031 SHALL instantiate one sub-module, arb_timeout_ctr (load/enable/expire), for the timeout counter.

Verification
REQ-032 SHALL cover: i_req=1, i_adr=0x100, ack 1 cycle after mem_req with rdata=0xDEADBEEF -> i_done pulse at cycle 3, i_rdata=0xDEADBEEF, i_err=0.
REQ-033 SHALL cover: i_req and d_req together, d_we=1, d_adr=0x200, d_wdata=0x12345678, fixed priority -> mem_we=1, mem_adr=0x200 first; d_done, then one idle cycle, then fetch granted.
REQ-034 SHALL cover, with ARB_RR_EN: both requesters held asserted for 4 transactions -> grants D, I, D, I.
REQ-035 SHALL cover: TIMEOUT=4, no ack -> mem_req high 4 cycles, then d_done=1 and d_err=1 together, mem_req=0.
REQ-036 SHALL cover: reset asserted during GRANT_I, ack arriving afterwards -> no i_done, state IDLE, mem_req=0.
REQ-037 SHALL cover: mem_ack pulsed while idle -> no done pulses, no state change.
